clk_div_prog: RTL
=================

Name: clk_div_prog

Overview:
Parametrised programmable clock divider and tick generator. It replaces the fixed-ratio divider.
- Divide ratio and output mode are loadable at runtime.
- New settings take effect glitch-free at period boundaries.
- Outputs: a divided clock-enable-style waveform (clk_out) and a one-cycle period strobe (tick).
- Sits between the board clock and the slower blocks (display refresh, sampling timers), which consume clk_out or tick.

Parameters:
WIDTH, 16, bit width of the divide-ratio counter and div_val.
DEFAULT_DIV, 4, active ratio N after reset; must satisfy 1 <= DEFAULT_DIV < 2^WIDTH.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  run control; low = idle/hold.
load  input  1  one-cycle strobe; captures div_val and mode.
div_val  input  WIDTH  requested ratio N; 0 is treated as 1.
mode  input  1  0 = toggle (output period 2N), 1 = duty (output period N).
clk_out  output  1  divided waveform, registered.
tick  output  1  one-cycle strobe each N enabled cycles, registered.
pend  output  1  shadow setting waiting for the next period boundary.

Behaviour:
- Registers: cnt[WIDTH-1:0], n_act, mode_act, n_shd, mode_shd, pend, clk_out, tick.
- Reset (sync, highest priority): cnt=0, n_act=DEFAULT_DIV, mode_act=0, pend=0, clk_out=0, tick=0. Reset mid-period aborts the period; any pending load is discarded.
- Ratio sanitising: N = (div_val==0) ? 1 : div_val, applied at capture.
- Counting, enable=1, each edge:
  - If cnt==n_act-1: cnt<=0 and tick<=1 (period boundary).
  - Otherwise: cnt<=cnt+1 and tick<=0.
  - With cnt=0 at enable, the first tick is high in the cycle after edge N-1. tick then has period exactly N cycles.
- Toggle mode (mode_act=0): clk_out inverts at each boundary, so output period is 2N with 50% duty. N=1 gives clk/2.
- Duty mode (mode_act=1): clk_out <= (cnt_next < H), where H = n_act>>1 and cnt_next is the value cnt takes at that edge.
  - Gives H cycles high, N-H low, period N.
  - N=1: clk_out held 1.
- Load handling:
  - load with enable=0: n_act/mode_act updated directly at that edge; pend stays 0.
  - load with enable=1, not on a boundary: n_shd/mode_shd captured, pend<=1. At the next boundary n_act<=n_shd, mode_act<=mode_shd, pend<=0.
  - load in the same cycle as a boundary: the new values are written straight into n_act/mode_act for the period starting now; pend stays 0.
  - A second load while pend=1 overwrites the shadow; last write wins.
- Mode change at a boundary: clk_out is recomputed under the new mode. Toggle→duty resynchronises clk_out high for cnt=0. Duty→toggle starts from the current clk_out value, inverted.
- enable=0 (idle): cnt<=0, tick<=0, clk_out<=0, settings retained. On return to enable=1, counting restarts from cnt=0; no tick on the enable edge itself.
- Wrap: cnt never exceeds n_act-1. N=2^WIDTH-1 is the maximum and is legal.

Optional Feature:
DIV_PHASE_SYNC_EN
- Defined: adds input sync_in (1 bit, placed after mode). A cycle with sync_in=1 and enable=1 forces cnt<=0 and clk_out<=0 with no tick, so several dividers can be phase-aligned.
  - sync_in in the same cycle as a boundary: sync wins and no tick is emitted.
  - Pending load is applied at that sync edge.
- Undefined: port absent; behaviour as above.

Test Plan:
- Reset, enable=1, defaults (N=4, mode 0) → tick every 4 cycles; clk_out high 4, low 4, period 8; first tick 4 cycles after enable sampled.
- load div_val=3 at cnt=1 → pend=1 until the current 4-cycle period ends; then tick period 3, clk_out period 6, pend=0.
- load div_val=0, mode=0 → treated as N=1: tick high every cycle, clk_out toggles every cycle.
- load div_val=5, mode=1 → clk_out pattern 1,1,0,0,0 repeating, tick once per 5 cycles.
- enable dropped mid-period with N=6 → next cycle clk_out=0, tick=0, cnt=0. Re-enable → first tick after 6 cycles.
- Assert reset mid-period with pend=1 (shadow N=9) → all outputs 0, N back to 4, pend=0. Next period length is 4, not 9.

Source files
------------

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_prog
//  Brief    : Programmable clock divider / tick generator with shadowed,
//             boundary-aligned ratio and mode updates. Optional phase-sync
//             input enabled by defining DIV_PHASE_SYNC_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] div_val,
    input  logic             mode,
`ifdef DIV_PHASE_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    localparam logic [WIDTH-1:0] c_one         = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_default_div = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_n_act;
    logic             r_mode_act;
    logic [WIDTH-1:0] r_n_shd;
    logic             r_mode_shd;
    logic             r_pend;
    logic             r_clk_out;
    logic             r_tick;

    logic [WIDTH-1:0] w_div_san;
    logic [WIDTH-1:0] w_cnt_inc;
    logic             w_boundary;
    logic [WIDTH-1:0] w_n_new;
    logic             w_mode_new;
    logic             w_sync;

    // Duty-mode level for the count value about to be entered; N=1 stays high.
    function automatic logic f_duty(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] c);
        return (n == c_one) ? 1'b1 : (c < (n >> 1));
    endfunction

    assign w_div_san  = (div_val == '0) ? c_one : div_val;
    assign w_cnt_inc  = r_cnt + c_one;
    assign w_boundary = (r_cnt == (r_n_act - c_one));

`ifdef DIV_PHASE_SYNC_EN
    assign w_sync = sync_in;
`else
    assign w_sync = 1'b0;
`endif

    // Settings for the period that starts at this edge: a same-cycle load
    // beats a pending shadow, which beats the current active values.
    always_comb begin
        w_n_new    = r_n_act;
        w_mode_new = r_mode_act;
        if (load) begin
            w_n_new    = w_div_san;
            w_mode_new = mode;
        end else if (r_pend) begin
            w_n_new    = r_n_shd;
            w_mode_new = r_mode_shd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_n_act    <= c_default_div;
            r_mode_act <= 1'b0;
            r_n_shd    <= c_default_div;
            r_mode_shd <= 1'b0;
            r_pend     <= 1'b0;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
        end else if (!enable) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
            if (load) begin
                r_n_act    <= w_div_san;
                r_mode_act <= mode;
                r_pend     <= 1'b0;
            end
        end else if (w_sync) begin
            r_cnt      <= '0;
            r_tick     <= 1'b0;
            r_clk_out  <= 1'b0;
            r_n_act    <= w_n_new;
            r_mode_act <= w_mode_new;
            r_pend     <= 1'b0;
        end else if (w_boundary) begin
            r_cnt      <= '0;
            r_tick     <= 1'b1;
            r_n_act    <= w_n_new;
            r_mode_act <= w_mode_new;
            r_pend     <= 1'b0;
            r_clk_out  <= w_mode_new ? f_duty(w_n_new, '0) : ~r_clk_out;
        end else begin
            r_cnt     <= w_cnt_inc;
            r_tick    <= 1'b0;
            r_clk_out <= r_mode_act ? f_duty(r_n_act, w_cnt_inc) : r_clk_out;
            if (load) begin
                r_n_shd    <= w_div_san;
                r_mode_shd <= mode;
                r_pend     <= 1'b1;
            end
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign pend    = r_pend;

endmodule
`default_nettype wire
